// File: rtl/xbar_pkg.sv
// Shared crossbar constants and types: default bus widths, command encoding,
// slave responder state encoding, and the wait counter load helper.
package xbar_pkg;

  localparam int DATA_W = 11;
  localparam int ADDR_W = 11;

  localparam logic CMD_READ  = 1'b0;
  localparam logic CMD_WRITE = 1'b1;

  localparam int WAIT_CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    ACK,
    RESP
  } slave_state_t;

  // The counter is loaded with one less than the wait-state count because the
  // WAIT state exits on the cycle the counter reads zero.
  function automatic logic [WAIT_CNT_W-1:0] wait_load(input int wait_states);
    logic [WAIT_CNT_W-1:0] ld;
    ld = '0;
    if (wait_states > 0) ld = WAIT_CNT_W'(wait_states - 1);
    return ld;
  endfunction

endpackage

// File: rtl/xbar_slave_mem_array.sv
// Word array behind the slave responder: one synchronous write port, one
// registered read port with enable; every word and the read register clear on reset.
module xbar_slave_mem_array #(
  parameter int DATA_W = 11,
  parameter int MEM_AW = 6
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              wr_en,
  input  logic [MEM_AW-1:0] wr_idx,
  input  logic [DATA_W-1:0] wr_dat,
  input  logic              rd_en,
  input  logic [MEM_AW-1:0] rd_idx,
  output logic [DATA_W-1:0] rd_dat
);

  localparam int DEPTH = 1 << MEM_AW;

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_en) begin
      mem[wr_idx] <= wr_dat;
    end
  end

  // Read register holds its value between reads; consumers qualify it with resp.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rd_dat <= '0;
    end else if (rd_en) begin
      rd_dat <= mem[rd_idx];
    end
  end

endmodule

// File: rtl/xbar_slave_mem.sv
// Memory-backed crossbar slave: ack at T+1+WAIT_STATES, read resp one cycle later.
// Requests are held by the crossbar until ack; dropping req before ack abandons it.
module xbar_slave_mem #(
  parameter int DATA_W      = 11,
  parameter int ADDR_W      = 11,
  parameter int MEM_AW      = 6,
  parameter int WAIT_STATES = 0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              slave_req,
  input  logic [ADDR_W-1:0] slave_addr,
  input  logic              slave_cmd,
  input  logic [DATA_W-1:0] slave_wdata,
  output logic              slave_ack,
  output logic [DATA_W-1:0] slave_rdata,
  output logic              slave_resp
);

  import xbar_pkg::*;

  localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD = wait_load(WAIT_STATES);

  slave_state_t          state_q, state_d;
  logic [WAIT_CNT_W-1:0] wcnt_q, wcnt_d;
  logic                  wr_en;
  logic                  rd_en;
  logic [MEM_AW-1:0]     word_idx;

  // Upper address bits were already decoded by the crossbar.
  assign word_idx = slave_addr[MEM_AW-1:0];

  generate
    if (ADDR_W > MEM_AW) begin : g_addr_hi
      logic unused_addr_hi;
      assign unused_addr_hi = ^slave_addr[ADDR_W-1:MEM_AW];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    wcnt_d     = wcnt_q;
    slave_ack  = 1'b0;
    slave_resp = 1'b0;
    wr_en      = 1'b0;
    rd_en      = 1'b0;
    case (state_q)
      // RESP accepts a new request exactly like IDLE so reads pipeline back-to-back.
      IDLE, RESP: begin
        slave_resp = (state_q == RESP);
        if (slave_req) begin
          if (WAIT_STATES > 0) begin
            state_d = WAIT;
            wcnt_d  = WAIT_LOAD;
          end else begin
            state_d = ACK;
          end
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        if (!slave_req) begin
          state_d = IDLE;
          wcnt_d  = '0;
        end else if (wcnt_q == '0) begin
          state_d = ACK;
        end else begin
          wcnt_d = wcnt_q - 1'b1;
        end
      end
      ACK: begin
        slave_ack = slave_req;
        state_d   = IDLE;
        if (slave_req) begin
          if (slave_cmd == CMD_WRITE) begin
            wr_en = 1'b1;
          end else begin
            rd_en   = 1'b1;
            state_d = RESP;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  xbar_slave_mem_array #(
    .DATA_W(DATA_W),
    .MEM_AW(MEM_AW)
  ) u_array (
    .clk    (clk),
    .reset_n(reset_n),
    .wr_en  (wr_en),
    .wr_idx (word_idx),
    .wr_dat (slave_wdata),
    .rd_en  (rd_en),
    .rd_idx (word_idx),
    .rd_dat (slave_rdata)
  );

endmodule

// File: tb/tb_xbar_slave_mem.sv
// Six responders with different wait-state counts share one clock; a timing/data
// model predicts ack and resp cycles, and a negedge monitor scores every cycle.
module tb_xbar_slave_mem;

  localparam int N = 6;

  function automatic int ws_of(input int i);
    case (i)
      0:       return 0;
      1:       return 1;
      2:       return 2;
      3:       return 3;
      4:       return 4;
      default: return 7;
    endcase
  endfunction

  typedef struct packed {
    int          inst;
    int          cyc;
    logic [10:0] dat;
  } ev_t;

  logic        clk;
  logic        reset_n;
  logic        req   [N];
  logic [10:0] addr  [N];
  logic        cmd   [N];
  logic [10:0] wdata [N];
  logic        ack   [N];
  logic [10:0] rdata [N];
  logic        resp  [N];

  int          cyc;
  int          passes;
  int          total;
  bit          mon_en;
  ev_t         ackq[$];
  ev_t         respq[$];
  logic [10:0] mdl [N][64];

  for (genvar g = 0; g < N; g++) begin : g_dut
    xbar_slave_mem #(
      .DATA_W(11),
      .ADDR_W(11),
      .MEM_AW(6),
      .WAIT_STATES(ws_of(g))
    ) u_dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .slave_req  (req[g]),
      .slave_addr (addr[g]),
      .slave_cmd  (cmd[g]),
      .slave_wdata(wdata[g]),
      .slave_ack  (ack[g]),
      .slave_rdata(rdata[g]),
      .slave_resp (resp[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
  endtask

  task automatic clear_model();
    for (int i = 0; i < N; i++)
      for (int w = 0; w < 64; w++) mdl[i][w] = '0;
  endtask

  task automatic drop_all();
    for (int k = 0; k < N; k++) req[k] = 1'b0;
  endtask

  task automatic idle(input int n);
    drop_all();
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Called #1 after a rising edge: the current cycle is T. Returns in cycle
  // T+2+WS with req still high, so a following call forms a back-to-back burst.
  task automatic txn(input int i, input bit wr, input logic [10:0] a, input logic [10:0] d);
    ev_t ev;
    drop_all();
    req[i] = 1'b1; cmd[i] = wr; addr[i] = a; wdata[i] = d;
    ev.inst = i; ev.cyc = cyc + 1 + ws_of(i); ev.dat = '0;
    ackq.push_back(ev);
    if (wr) begin
      mdl[i][a[5:0]] = d;
    end else begin
      ev.cyc = cyc + 2 + ws_of(i);
      ev.dat = mdl[i][a[5:0]];
      respq.push_back(ev);
    end
    repeat (2 + ws_of(i)) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin : monitor
    bit          ea [N];
    bit          er [N];
    logic [10:0] ed [N];
    ev_t         ev;
    if (mon_en) begin
      for (int i = 0; i < N; i++) begin
        ea[i] = 1'b0; er[i] = 1'b0; ed[i] = '0;
      end
      while (ackq.size() > 0 && ackq[0].cyc <= cyc) begin
        ev = ackq.pop_front();
        if (ev.cyc == cyc) ea[ev.inst] = 1'b1;
        else chk($sformatf("ack_missed[%0d]", ev.inst), 32'(ev.cyc), 32'(cyc));
      end
      while (respq.size() > 0 && respq[0].cyc <= cyc) begin
        ev = respq.pop_front();
        if (ev.cyc == cyc) begin
          er[ev.inst] = 1'b1; ed[ev.inst] = ev.dat;
        end else begin
          chk($sformatf("resp_missed[%0d]", ev.inst), 32'(ev.cyc), 32'(cyc));
        end
      end
      for (int i = 0; i < N; i++) begin
        if (ea[i] || ack[i]) chk($sformatf("ack[%0d]", i), 32'(ack[i]), 32'(ea[i]));
        if (er[i] || resp[i]) chk($sformatf("resp[%0d]", i), 32'(resp[i]), 32'(er[i]));
        if (er[i]) chk($sformatf("rdata[%0d]", i), 32'(rdata[i]), 32'(ed[i]));
        if (ack[i] || resp[i]) chk($sformatf("ack_resp_excl[%0d]", i), 32'(ack[i] & resp[i]), 32'd0);
      end
    end
  end

  task automatic check_quiet(input string tag);
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      chk($sformatf("%s_ack[%0d]", tag, i), 32'(ack[i]), 32'd0);
      chk($sformatf("%s_resp[%0d]", tag, i), 32'(resp[i]), 32'd0);
      chk($sformatf("%s_rdata[%0d]", tag, i), 32'(rdata[i]), 32'd0);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          i;
    logic [10:0] a;
    passes = 0; total = 0; mon_en = 1'b0;
    reset_n = 1'b0;
    for (int k = 0; k < N; k++) begin
      req[k] = 1'b0; addr[k] = '0; cmd[k] = 1'b0; wdata[k] = '0;
    end
    clear_model();
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    check_quiet("reset");
    mon_en = 1'b1;

    // Single write then read, no wait states.
    txn(0, 1'b1, 11'h003, 11'h155);
    txn(0, 1'b0, 11'h003, 11'h000);
    idle(2);

    // Three wait states; upper address bits alias to the same word.
    txn(3, 1'b0, 11'h7C5, 11'h000);
    idle(1);
    txn(3, 1'b1, 11'h045, 11'h2AB);
    idle(1);
    txn(3, 1'b0, 11'h7C5, 11'h000);
    idle(2);

    // Back-to-back burst with req held high throughout.
    txn(0, 1'b1, 11'h010, 11'h011);
    txn(0, 1'b1, 11'h011, 11'h022);
    txn(0, 1'b0, 11'h010, 11'h000);
    txn(0, 1'b0, 11'h011, 11'h000);
    idle(2);

    // Abandon in the first WAIT cycle: no ack, no resp, no write.
    req[2] = 1'b1; cmd[2] = 1'b1; addr[2] = 11'h00A; wdata[2] = 11'h1AA;
    @(posedge clk);
    #1;
    req[2] = 1'b0;
    idle(3);
    txn(2, 1'b0, 11'h00A, 11'h000);
    txn(2, 1'b1, 11'h00A, 11'h0F0);
    txn(2, 1'b0, 11'h00A, 11'h000);
    idle(2);

    // Reset while a read is waiting: the read is dropped and memory clears.
    txn(4, 1'b1, 11'h002, 11'h3FF);
    txn(4, 1'b0, 11'h002, 11'h000);
    idle(2);
    req[4] = 1'b1; cmd[4] = 1'b0; addr[4] = 11'h002;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b0;
    req[4] = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    clear_model();
    check_quiet("midreset");
    txn(4, 1'b0, 11'h002, 11'h000);
    idle(2);

    // Random traffic across the 0/1/7 wait-state responders.
    for (int n = 0; n < 2000; n++) begin
      case ($urandom_range(0, 2))
        0:       i = 0;
        1:       i = 1;
        default: i = 5;
      endcase
      a = 11'($urandom);
      a[5:0] = 6'($urandom_range(0, 7));
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 2));
      txn(i, 1'($urandom_range(0, 1)), a, 11'($urandom));
    end
    idle(15);
    chk("queue_drain", 32'(ackq.size() + respq.size()), 32'd0);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
